// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the single shared memory port to fetch reads, memory-stage
// reads or memory-stage writes, one outstanding transaction at a time.
// Optional fetch anti-starvation counter is enabled by defining MEM_ARB_ANTI_STARVE_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] if_r_addr,
  input  logic                  if_r_addr_valid,
  output logic [DATA_WIDTH-1:0] if_r_data,
  output logic                  if_r_data_valid,
  input  logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic                  mem_r_addr_valid,
  output logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  mem_r_data_valid,
  input  logic                  mem_w_valid,
  input  logic [ADDR_WIDTH-1:0] mem_w_addr,
  input  logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [3:0]            mem_w_size,
  output logic                  mem_w_ready,
  output logic                  mem_w_complete,
  output logic [ADDR_WIDTH-1:0] m_r_addr,
  output logic                  m_r_addr_valid,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  input  logic                  m_r_data_valid,
  output logic                  m_w_valid,
  output logic [ADDR_WIDTH-1:0] m_w_addr,
  output logic [DATA_WIDTH-1:0] m_w_data,
  output logic [3:0]            m_w_size,
  input  logic                  m_w_ready,
  input  logic                  m_w_complete,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_RD   = 3'd1,
    S_MEM_RD  = 3'd2,
    S_MEM_WR  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_t;

  localparam logic [1:0] GID_NONE   = 2'd0;
  localparam logic [1:0] GID_IF_RD  = 2'd1;
  localparam logic [1:0] GID_MEM_RD = 2'd2;
  localparam logic [1:0] GID_MEM_WR = 2'd3;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [3:0]            r_size;
  logic                  r_m_r_addr_valid;
  logic                  r_m_w_valid;
  logic                  r_mem_w_ready;
  logic                  r_busy;
  logic [1:0]            r_grant_id;

  logic w_pick_if;
  logic w_pick_mr;
  logic w_pick_mw;
  logic w_fetch_starved;

`ifdef MEM_ARB_ANTI_STARVE_EN
  localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] r_starve_cnt;

  assign w_fetch_starved = if_r_addr_valid && (r_starve_cnt >= LP_STARVE_LIMIT);

  // Counts cycles fetch is pending without ownership; saturates so it never wraps back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_pick_if) begin
      r_starve_cnt <= '0;
    end else if (if_r_addr_valid && (r_state != S_IF_RD) && (r_starve_cnt != 8'hFF)) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end
`else
  logic w_unused_starve_limit;
  assign w_fetch_starved       = 1'b0;
  assign w_unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  always_comb begin
    w_pick_if = 1'b0;
    w_pick_mr = 1'b0;
    w_pick_mw = 1'b0;
    if (w_fetch_starved) begin
      w_pick_if = 1'b1;
    end else if (mem_w_valid) begin
      w_pick_mw = 1'b1;
    end else if (mem_r_addr_valid) begin
      w_pick_mr = 1'b1;
    end else if (if_r_addr_valid) begin
      w_pick_if = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_addr           <= '0;
      r_data           <= '0;
      r_size           <= '0;
      r_m_r_addr_valid <= 1'b0;
      r_m_w_valid      <= 1'b0;
      r_mem_w_ready    <= 1'b0;
      r_busy           <= 1'b0;
      r_grant_id       <= GID_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_mw) begin
            r_state       <= S_MEM_WR;
            r_addr        <= mem_w_addr;
            r_data        <= mem_w_data;
            r_size        <= mem_w_size;
            r_m_w_valid   <= 1'b1;
            r_mem_w_ready <= 1'b1;
            r_busy        <= 1'b1;
            r_grant_id    <= GID_MEM_WR;
          end else if (w_pick_mr) begin
            r_state          <= S_MEM_RD;
            r_addr           <= mem_r_addr;
            r_m_r_addr_valid <= 1'b1;
            r_busy           <= 1'b1;
            r_grant_id       <= GID_MEM_RD;
          end else if (w_pick_if) begin
            r_state          <= S_IF_RD;
            r_addr           <= if_r_addr;
            r_m_r_addr_valid <= 1'b1;
            r_busy           <= 1'b1;
            r_grant_id       <= GID_IF_RD;
          end
        end
        S_IF_RD, S_MEM_RD: begin
          if (m_r_data_valid) begin
            r_state          <= S_IDLE;
            r_m_r_addr_valid <= 1'b0;
            r_busy           <= 1'b0;
            r_grant_id       <= GID_NONE;
          end
        end
        S_MEM_WR: begin
          if (m_w_ready) begin
            r_state     <= S_WR_WAIT;
            r_m_w_valid <= 1'b0;
          end
        end
        S_WR_WAIT: begin
          if (m_w_complete) begin
            r_state       <= S_IDLE;
            r_mem_w_ready <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_id    <= GID_NONE;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_m_r_addr_valid <= 1'b0;
          r_m_w_valid      <= 1'b0;
          r_mem_w_ready    <= 1'b0;
          r_busy           <= 1'b0;
          r_grant_id       <= GID_NONE;
        end
      endcase
    end
  end

  // Response pulses are combinational so the requester sees them in the response cycle.
  assign if_r_data_valid  = (r_state == S_IF_RD) && m_r_data_valid;
  assign mem_r_data_valid = (r_state == S_MEM_RD) && m_r_data_valid;
  assign mem_w_complete   = (r_state == S_WR_WAIT) && m_w_complete;
  assign if_r_data        = m_r_data;
  assign mem_r_data       = m_r_data;

  assign m_r_addr       = r_addr;
  assign m_r_addr_valid = r_m_r_addr_valid;
  assign m_w_valid      = r_m_w_valid;
  assign m_w_addr       = r_addr;
  assign m_w_data       = r_data;
  assign m_w_size       = r_size;
  assign mem_w_ready    = r_mem_w_ready;
  assign busy           = r_busy;
  assign grant_id       = r_grant_id;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between the fetch stage (read-only) and the memory stage (read and write). The memory stage's read/write handshake and the fetch read handshake enter as requesters. One transaction is issued to the shared port at a time. The block sits between the pipeline stages and the cache/memory controller, owns the only path to it, and guarantees one outstanding transaction.

## Interface
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, data width
- STARVE_LIMIT, 16, cycles fetch may wait before forced grant (only with MEM_ARB_ANTI_STARVE_EN)

Clock and reset: reset reset, synchronous, active-high; clock clk.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_r_addr  in  ADDR_WIDTH  fetch read address
- if_r_addr_valid  in  1  fetch read request, level, held until if_r_data_valid
- if_r_data  out  DATA_WIDTH  read data to fetch
- if_r_data_valid  out  1  one-cycle pulse, fetch data valid
- mem_r_addr  in  ADDR_WIDTH  memory-stage read address
- mem_r_addr_valid  in  1  memory-stage read request, level
- mem_r_data  out  DATA_WIDTH  read data to memory stage
- mem_r_data_valid  out  1  one-cycle pulse
- mem_w_valid  in  1  memory-stage write request, level, held until mem_w_complete
- mem_w_addr / mem_w_data / mem_w_size  in  ADDR_WIDTH / DATA_WIDTH / 4  write address, data, size
- mem_w_ready  out  1  high while the write is granted
- mem_w_complete  out  1  one-cycle pulse, write done
- m_r_addr  out  ADDR_WIDTH  shared port read address
- m_r_addr_valid  out  1  shared port read request
- m_r_data  in  DATA_WIDTH  shared port read data
- m_r_data_valid  in  1  shared port data pulse
- m_w_valid / m_w_addr / m_w_data / m_w_size  out  1 / ADDR_WIDTH / DATA_WIDTH / 4  shared port write
- m_w_ready  in  1  downstream accepts write
- m_w_complete  in  1  downstream write-done pulse
- busy  out  1  state != IDLE
- grant_id  out  2  0 none, 1 fetch read, 2 mem read, 3 mem write

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, WR_WAIT.
- IDLE: sample requests. Priority: mem_w_valid > mem_r_addr_valid > if_r_addr_valid. Latch the winner's address, data and size into internal registers and go to the grant state. With no request, stay in IDLE.
- IF_RD / MEM_RD:
  - m_r_addr_valid = 1 and m_r_addr = latched address.
  - On m_r_data_valid, pulse the owner's *_r_data_valid, then go to IDLE.
  - *_r_data are wired to m_r_data continuously; only the valid is gated by owner.
- MEM_WR: m_w_valid = 1 with latched fields. When m_w_ready is high, go to WR_WAIT. mem_w_ready is high in MEM_WR and WR_WAIT.
- WR_WAIT: hold m_w_valid low. On m_w_complete, pulse mem_w_complete, then go to IDLE.
- Latched fields are frozen for the whole transaction. Requester changes mid-transaction are ignored.
- A requester dropping valid before completion does not abort the transaction. It completes and its result pulse is still issued.
- A response pulse arriving in a non-matching state (e.g. m_r_data_valid in MEM_WR) is ignored.

## Timing
- Reset values: all valids, pulses, mem_w_ready and busy are 0; grant_id is 0; state is IDLE; latches are 0.
- A request sampled in IDLE at cycle N gives downstream valid at N+1.
- Response at cycle M gives the requester pulse at M (combinational) and IDLE at M+1.
- Next grant is decided at M+1 and issued at M+2. Minimum read occupancy is 2 cycles per transaction.
- Simultaneous requests: strict priority above. Losers stay pending and see no pulse.
- A request still high in the IDLE cycle after its own completion is treated as a new request. Requesters must deassert in the pulse cycle.
- Reset mid-transaction returns to IDLE next edge and drops the outstanding transaction. Downstream must share the reset.

## Configuration
- MEM_ARB_ANTI_STARVE_EN defined: an 8-bit wait counter increments each cycle if_r_addr_valid is high and fetch is not granted, and clears on fetch grant. When the counter is ≥ STARVE_LIMIT in IDLE, fetch beats both memory-stage requests.
- MEM_ARB_ANTI_STARVE_EN undefined: no counter, strict priority only.

## Test plan
- Fetch read alone: if_r_addr=0x1000 held, m_r_data=0xDEAD with valid 3 cycles after m_r_addr_valid → if_r_data_valid single pulse with data 0xDEAD; mem_r_data_valid stays 0; grant_id=1 during.
- Simultaneous fetch read 0x2000 and mem read 0x841A0 → mem read issued first (m_r_addr=0x841A0), fetch issued at completion+2 cycles with m_r_addr=0x2000.
- Mem write addr 0x3000, data 0x28, size 4, m_w_ready delayed 2 cycles, m_w_complete 2 cycles later → m_w_valid high until ready, then low; mem_w_complete one pulse; fields unchanged throughout.
- mem_r_addr changed to 0x9999 mid-read → m_r_addr stays at the originally latched value.
- Reset asserted in MEM_RD → next cycle state IDLE, m_r_addr_valid=0, busy=0; a late m_r_data_valid produces no pulse.
- With MEM_ARB_ANTI_STARVE_EN and STARVE_LIMIT=4, memory stage back-to-back reading while fetch requests → fetch granted no later than the first IDLE after 4 waiting cycles. Without the macro, fetch starves until mem requests stop.
